// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the two-requester single-port SRAM arbiter.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr names the requester that wins a tie.
module rr_arb2
    import sram_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic ptr;
    logic ptr_nxt;

    // Grant the lone requester, or the one holding priority when both ask
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        ptr_nxt = ptr;
        if (en) begin
            if (req_a && (!req_b || ptr == REQ_A)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
        if (gnt_a) begin
            ptr_nxt = REQ_B;
        end else if (gnt_b) begin
            ptr_nxt = REQ_A;
        end
    end

    // Priority pointer: hands the tie to the other requester after each grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= REQ_A;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port RAM between requesters A and B; clears the array
// after reset, then arbitrates round-robin with read data one cycle later.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 34,
    parameter bit INIT_EN = 1'b1
)(
    input  logic          CLK,
    input  logic          RST,
    input  logic          A_VALID,
    output logic          A_READY,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADR,
    input  logic [DW-1:0] A_D,
    output logic          A_RVALID,
    output logic [DW-1:0] A_Q,
    input  logic          B_VALID,
    output logic          B_READY,
    input  logic          B_WE,
    input  logic [AW-1:0] B_ADR,
    input  logic [DW-1:0] B_D,
    output logic          B_RVALID,
    output logic [DW-1:0] B_Q,
    output logic [AW-1:0] MEM_ADR,
    output logic [DW-1:0] MEM_D,
    output logic          MEM_WE,
    input  logic [DW-1:0] MEM_Q,
    output logic          INIT_DONE
);

    // One extra counter bit keeps the last-address compare free of wrap aliasing
    localparam logic [AW:0] LAST_ADR = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   cnt;
    logic          gnt_a;
    logic          gnt_b;
    logic [AW-1:0] adr_hold;
    logic [DW-1:0] d_hold;
    logic          rd_vld;
    logic          rd_owner;

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst   (RST),
        .en    (state == RUN),
        .req_a (A_VALID),
        .req_b (B_VALID),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign A_READY  = gnt_a;
    assign B_READY  = gnt_b;
    assign A_Q      = MEM_Q;
    assign B_Q      = MEM_Q;
    assign A_RVALID = rd_vld && (rd_owner == REQ_A);
    assign B_RVALID = rd_vld && (rd_owner == REQ_B);

    // Next state: one IDLE cycle, optional clearing sweep, then RUN forever
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = INIT_EN ? INIT : RUN;
            INIT:    if (cnt == LAST_ADR) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // State, sweep counter and the registered init-complete flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            INIT_DONE <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state == INIT) ? cnt + CNT_ONE : '0;
            INIT_DONE <= (state_nxt == RUN);
        end
    end

    // RAM pin mux: sweep writes in INIT, granted requester in RUN, else hold
    always_comb begin
        MEM_WE  = 1'b0;
        MEM_ADR = adr_hold;
        MEM_D   = d_hold;
        case (state)
            IDLE: begin
                MEM_ADR = '0;
                MEM_D   = '0;
            end
            INIT: begin
                MEM_WE  = 1'b1;
                MEM_ADR = cnt[AW-1:0];
                MEM_D   = '0;
            end
            RUN: begin
                if (gnt_a) begin
                    MEM_WE  = A_WE;
                    MEM_ADR = A_ADR;
                    MEM_D   = A_D;
                end else if (gnt_b) begin
                    MEM_WE  = B_WE;
                    MEM_ADR = B_ADR;
                    MEM_D   = B_D;
                end
            end
            default: begin
                MEM_ADR = '0;
                MEM_D   = '0;
            end
        endcase
    end

    // Remember the last driven address/data so idle cycles do not toggle the pins
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            adr_hold <= '0;
            d_hold   <= '0;
        end else begin
            adr_hold <= MEM_ADR;
            d_hold   <= MEM_D;
        end
    end

    // Response tag: which requester owns the RAM output next cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_vld   <= 1'b0;
            rd_owner <= REQ_A;
        end else begin
            rd_vld   <= (gnt_a && !A_WE) || (gnt_b && !B_WE);
            rd_owner <= gnt_b ? REQ_B : REQ_A;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: RAM model on the MEM pins plus a reference
// model of the arbitration, array contents and response timing.
module tb_sram_port_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 34;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_adr;
    logic [DW-1:0] a_d, a_q;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_adr;
    logic [DW-1:0] b_d, b_q;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_d, mem_q;
    logic          mem_we, init_done;

    sram_port_arbiter #(.AW(AW), .DW(DW), .INIT_EN(1'b1)) dut (
        .CLK(clk), .RST(rst),
        .A_VALID(a_valid), .A_READY(a_ready), .A_WE(a_we), .A_ADR(a_adr), .A_D(a_d),
        .A_RVALID(a_rvalid), .A_Q(a_q),
        .B_VALID(b_valid), .B_READY(b_ready), .B_WE(b_we), .B_ADR(b_adr), .B_D(b_d),
        .B_RVALID(b_rvalid), .B_Q(b_q),
        .MEM_ADR(mem_adr), .MEM_D(mem_d), .MEM_WE(mem_we), .MEM_Q(mem_q),
        .INIT_DONE(init_done)
    );

    // Single-port RAM: write commits on the edge, Q is registered
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_adr] <= mem_d;
        mem_q <= ram[mem_adr];
    end

    // Second instance without the clearing sweep
    logic          rst2;
    logic          c_a_valid, c_a_ready, c_a_we, c_a_rvalid;
    logic [3:0]    c_a_adr, c_b_adr, c_mem_adr;
    logic [DW-1:0] c_a_d, c_a_q, c_b_d, c_b_q, c_mem_d, c_mem_q;
    logic          c_b_valid, c_b_ready, c_b_we, c_b_rvalid, c_mem_we, c_init_done;

    sram_port_arbiter #(.AW(4), .DW(DW), .INIT_EN(1'b0)) dut2 (
        .CLK(clk), .RST(rst2),
        .A_VALID(c_a_valid), .A_READY(c_a_ready), .A_WE(c_a_we), .A_ADR(c_a_adr), .A_D(c_a_d),
        .A_RVALID(c_a_rvalid), .A_Q(c_a_q),
        .B_VALID(c_b_valid), .B_READY(c_b_ready), .B_WE(c_b_we), .B_ADR(c_b_adr), .B_D(c_b_d),
        .B_RVALID(c_b_rvalid), .B_Q(c_b_q),
        .MEM_ADR(c_mem_adr), .MEM_D(c_mem_d), .MEM_WE(c_mem_we), .MEM_Q(c_mem_q),
        .INIT_DONE(c_init_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_cycles;     // cycles since reset release
    bit            prio;         // 0: A wins a tie, 1: B wins a tie
    logic [AW-1:0] m_hold_adr;
    logic [DW-1:0] m_hold_d;
    bit            resp_a, resp_b;
    logic [DW-1:0] resp_q;
    bit            exp_ra, exp_rb, exp_we;
    logic [AW-1:0] exp_adr;
    logic [DW-1:0] exp_d;

    task automatic model_reset();
        m_cycles   = 0;
        prio       = 1'b0;
        m_hold_adr = '0;
        m_hold_d   = '0;
        resp_a     = 1'b0;
        resp_b     = 1'b0;
        resp_q     = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Expected combinational outputs for the current cycle
    task automatic model_comb();
        bit run;
        run    = (m_cycles >= DEPTH + 1);
        exp_ra = run && a_valid && (!b_valid || prio == 1'b0);
        exp_rb = run && b_valid && !exp_ra;
        exp_we = 1'b0;
        exp_adr = m_hold_adr;
        exp_d   = m_hold_d;
        if (m_cycles == 0) begin
            exp_adr = '0;
            exp_d   = '0;
        end else if (!run) begin
            exp_we  = 1'b1;
            exp_adr = AW'(m_cycles - 1);
            exp_d   = '0;
        end else if (exp_ra) begin
            exp_we = a_we; exp_adr = a_adr; exp_d = a_d;
        end else if (exp_rb) begin
            exp_we = b_we; exp_adr = b_adr; exp_d = b_d;
        end
    endtask

    // Effects of the clock edge ending the current cycle
    task automatic model_commit();
        resp_a = exp_ra && !a_we;
        resp_b = exp_rb && !b_we;
        resp_q = exp_ra ? ref_mem[a_adr] : ref_mem[b_adr];
        if (exp_ra && a_we) ref_mem[a_adr] = a_d;
        if (exp_rb && b_we) ref_mem[b_adr] = b_d;
        if (exp_ra) prio = 1'b1;
        else if (exp_rb) prio = 1'b0;
        m_hold_adr = exp_adr;
        m_hold_d   = exp_d;
        m_cycles++;
    endtask

    task automatic settle();
        @(negedge clk);
        model_comb();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_we = 1'b0; b_we = 1'b0;
        a_adr = '0; b_adr = '0; a_d = '0; b_d = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %0b want 0", init_done); end
        checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", {a_ready, b_ready}); end
        checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b want 00", {a_rvalid, b_rvalid}); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0b want 0", mem_we); end
        checks++; if (mem_adr !== '0 || mem_d !== '0) begin errors++; $display("FAIL rst_mem_pins got %h/%h want 0/0", mem_adr, mem_d); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < DEPTH + 3; k++) begin
            a_valid = (k < DEPTH + 1) ? k[0] : 1'b0;
            b_valid = (k < DEPTH + 1) ? k[1] : 1'b0;
            a_adr   = AW'($urandom_range(0, 255));
            b_adr   = AW'($urandom_range(0, 255));
            settle();
            checks++; if ({a_ready, b_ready} !== {exp_ra, exp_rb}) begin errors++; $display("FAIL init_ready k=%0d got %b want %b", k, {a_ready, b_ready}, {exp_ra, exp_rb}); end
            checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL init_mem_we k=%0d got %0b want %0b", k, mem_we, exp_we); end
            checks++; if (mem_adr !== exp_adr || mem_d !== exp_d) begin errors++; $display("FAIL init_mem_pins k=%0d got %h/%h want %h/%h", k, mem_adr, mem_d, exp_adr, exp_d); end
            checks++; if (init_done !== (k >= DEPTH + 1)) begin errors++; $display("FAIL init_done k=%0d got %0b want %0b", k, init_done, (k >= DEPTH + 1)); end
            advance();
        end
    endtask

    task automatic test_write_read();
        a_valid = 1'b1; a_we = 1'b1; a_adr = 8'h12; a_d = 34'h3_0000_ABCD; b_valid = 1'b0;
        settle();
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL wr_ready got %b want 10", {a_ready, b_ready}); end
        checks++; if (mem_we !== 1'b1 || mem_adr !== 8'h12 || mem_d !== 34'h3_0000_ABCD) begin errors++; $display("FAIL wr_mem_pins got %0b/%h/%h want 1/12/30000abcd", mem_we, mem_adr, mem_d); end
        advance();
        a_valid = 1'b0; b_valid = 1'b1; b_we = 1'b0; b_adr = 8'h12;
        settle();
        checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL rd_ready got %b want 01", {a_ready, b_ready}); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we got %0b want 0", mem_we); end
        advance();
        b_valid = 1'b0;
        settle();
        checks++; if ({a_rvalid, b_rvalid} !== 2'b01) begin errors++; $display("FAIL rd_rvalid got %b want 01", {a_rvalid, b_rvalid}); end
        checks++; if (b_q !== 34'h3_0000_ABCD) begin errors++; $display("FAIL rd_b_q got %h want 30000abcd", b_q); end
        advance();
    endtask

    task automatic test_alternate();
        a_valid = 1'b1; a_we = 1'b1; a_adr = 8'd1; a_d = 34'd1; b_valid = 1'b0;
        settle(); advance();
        a_valid = 1'b0; b_valid = 1'b1; b_we = 1'b1; b_adr = 8'd2; b_d = 34'd2;
        settle(); advance();
        for (int i = 0; i < 5; i++) begin
            a_valid = (i < 4); a_we = 1'b0; a_adr = 8'd1;
            b_valid = (i < 4); b_we = 1'b0; b_adr = 8'd2;
            settle();
            if (i < 4) begin
                checks++; if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_grant i=%0d got %b", i, {a_ready, b_ready}); end
            end
            if (i > 0) begin
                checks++; if ({a_rvalid, b_rvalid} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_rvalid i=%0d got %b", i, {a_rvalid, b_rvalid}); end
                checks++; if (a_q !== (((i - 1) % 2 == 0) ? 34'd1 : 34'd2)) begin errors++; $display("FAIL alt_q i=%0d got %h want %0d", i, a_q, ((i - 1) % 2 == 0) ? 1 : 2); end
            end
            advance();
        end
    endtask

    task automatic test_unwritten();
        a_valid = 1'b1; a_we = 1'b0; a_adr = 8'hFF; b_valid = 1'b0;
        settle();
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL ff_ready got %0b want 1", a_ready); end
        advance();
        a_valid = 1'b0;
        settle();
        checks++; if ({a_rvalid, b_rvalid} !== 2'b10 || a_q !== '0) begin errors++; $display("FAIL ff_resp got %b/%h want 10/0", {a_rvalid, b_rvalid}, a_q); end
        advance();
    endtask

    task automatic test_random();
        bit a_hold = 1'b0;
        bit b_hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!a_hold) begin
                a_valid = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
                a_adr = AW'($urandom_range(0, 15)); a_d = DW'({$urandom(), $urandom()});
            end
            if (!b_hold) begin
                b_valid = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
                b_adr = AW'($urandom_range(0, 15)); b_d = DW'({$urandom(), $urandom()});
            end
            settle();
            checks++; if ({a_ready, b_ready} !== {exp_ra, exp_rb}) begin errors++; $display("FAIL rnd_ready i=%0d got %b want %b", i, {a_ready, b_ready}, {exp_ra, exp_rb}); end
            checks++; if (mem_we !== exp_we || mem_adr !== exp_adr || mem_d !== exp_d) begin errors++; $display("FAIL rnd_mem i=%0d got %0b/%h/%h want %0b/%h/%h", i, mem_we, mem_adr, mem_d, exp_we, exp_adr, exp_d); end
            checks++; if ({a_rvalid, b_rvalid} !== {resp_a, resp_b}) begin errors++; $display("FAIL rnd_rvalid i=%0d got %b want %b", i, {a_rvalid, b_rvalid}, {resp_a, resp_b}); end
            if (resp_a) begin
                checks++; if (a_q !== resp_q) begin errors++; $display("FAIL rnd_a_q i=%0d got %h want %h", i, a_q, resp_q); end
            end
            if (resp_b) begin
                checks++; if (b_q !== resp_q) begin errors++; $display("FAIL rnd_b_q i=%0d got %h want %h", i, b_q, resp_q); end
            end
            a_hold = a_valid && !exp_ra;
            b_hold = b_valid && !exp_rb;
            advance();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        settle();
        checks++; if ({a_rvalid, b_rvalid} !== {resp_a, resp_b}) begin errors++; $display("FAIL rnd_tail got %b want %b", {a_rvalid, b_rvalid}, {resp_a, resp_b}); end
        advance();
    endtask

    task automatic test_reset_mid();
        int budget;
        a_valid = 1'b1; a_we = 1'b1; a_adr = 8'h05; a_d = 34'h2_5555_0005; b_valid = 1'b0;
        settle(); advance();
        a_we = 1'b0;
        settle();
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_accept got %0b want 1", a_ready); end
        advance();
        rst = 1'b1; a_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid k=%0d got %0b want 0", k, a_rvalid); end
            checks++; if (mem_we !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL mid_we_done k=%0d got %0b/%0b want 0/0", k, mem_we, init_done); end
            @(posedge clk);
        end
        #1 rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mid_post_rvalid k=%0d got %0b want 0", k, a_rvalid); end
            checks++; if (mem_we !== (k >= 1) || mem_adr !== ((k >= 1) ? AW'(k - 1) : AW'(0))) begin errors++; $display("FAIL mid_sweep k=%0d got %0b/%h", k, mem_we, mem_adr); end
            advance();
        end
        budget = 0;
        while (m_cycles < DEPTH + 1 && budget < 400) begin
            settle(); advance(); budget++;
        end
        a_valid = 1'b1; a_we = 1'b0; a_adr = 8'h05;
        settle();
        checks++; if (a_ready !== 1'b1 || init_done !== 1'b1) begin errors++; $display("FAIL mid_rerun got %0b/%0b want 1/1", a_ready, init_done); end
        advance();
        a_valid = 1'b0;
        settle();
        checks++; if (a_rvalid !== 1'b1 || a_q !== '0) begin errors++; $display("FAIL mid_cleared got %0b/%h want 1/0", a_rvalid, a_q); end
        advance();
    endtask

    task automatic test_no_init();
        @(posedge clk); #1 rst2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (c_mem_we !== 1'b0 || c_a_ready !== 1'b0) begin errors++; $display("FAIL noinit_idle k=%0d got %0b/%0b want 0/0", k, c_mem_we, c_a_ready); end
            if (k == 0) begin
                checks++; if (c_init_done !== 1'b0) begin errors++; $display("FAIL noinit_done_early got %0b want 0", c_init_done); end
            end
            if (k >= 2) begin
                checks++; if (c_init_done !== 1'b1) begin errors++; $display("FAIL noinit_done k=%0d got %0b want 1", k, c_init_done); end
            end
            @(posedge clk); #1;
        end
        c_a_valid = 1'b1; c_a_we = 1'b1; c_a_adr = 4'd3; c_a_d = 34'd5;
        @(negedge clk);
        checks++; if (c_a_ready !== 1'b1 || c_mem_we !== 1'b1 || c_mem_adr !== 4'd3) begin errors++; $display("FAIL noinit_req got %0b/%0b/%h want 1/1/3", c_a_ready, c_mem_we, c_mem_adr); end
        @(posedge clk); #1 c_a_valid = 1'b0;
    endtask

    initial begin
        rst2 = 1'b1;
        c_a_valid = 1'b0; c_a_we = 1'b0; c_a_adr = '0; c_a_d = '0;
        c_b_valid = 1'b0; c_b_we = 1'b0; c_b_adr = '0; c_b_d = '0;
        c_mem_q = '0;
        test_reset();
        test_write_read();
        test_alternate();
        test_unwritten();
        test_random();
        test_reset_mid();
        test_no_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
